// File: rtl/cpu_arb_pkg.sv
// Shared state encoding and default bus widths for the CPU-cell bus arbiter.
package cpu_arb_pkg;

   localparam int ADDR_SIZE = 32;
   localparam int DATA_SIZE = 32;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot pick of the first requester
// after index i_last (wrapping), zero when nothing is requested.
module rr_pick
   import cpu_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [N-1:0]     o_pick
);

   always_comb begin
      logic w_found;
      // NOTE: every combinational output gets a default first so no latch is inferred.
      o_pick  = '0;
      w_found = 1'b0;
      for (int off = 1; off <= N; off++) begin
         for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i] && ((int'(i_last) + off) % N == i)) begin
               o_pick[i] = 1'b1;
               w_found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing the CPU-cell memory bus with one grant at a time.
// Optional build macro CPU_ARB_WRITE_PRIO_EN: pending writes win over reads.
module cpu_bus_arbiter
   import cpu_arb_pkg::*;
#(
   parameter int CPU_QUANTITY = 4,
   parameter int ADDR_W       = ADDR_SIZE,
   parameter int DATA_W       = DATA_SIZE
) (
   input  logic                           clk,
   input  logic                           rst_in,
   input  logic [CPU_QUANTITY-1:0]        cell_read_q,
   input  logic [CPU_QUANTITY-1:0]        cell_write_q,
   input  logic [CPU_QUANTITY*ADDR_W-1:0] cell_addr,
   input  logic [CPU_QUANTITY*DATA_W-1:0] cell_data,
   output logic [CPU_QUANTITY-1:0]        cell_read_dn,
   output logic [CPU_QUANTITY-1:0]        cell_write_dn,
   output logic [DATA_W-1:0]              cell_data_out,
   output logic [CPU_QUANTITY-1:0]        grant,
   input  logic                           rw_halt_in,
   output logic                           bus_read_q,
   output logic                           bus_write_q,
   output logic [ADDR_W-1:0]              bus_addr,
   output logic [DATA_W-1:0]              bus_data,
   input  logic                           bus_read_dn,
   input  logic                           bus_write_dn,
   input  logic [DATA_W-1:0]              bus_data_in,
   output logic                           bus_busy
);

   localparam int IDX_W = $clog2(CPU_QUANTITY);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(CPU_QUANTITY - 1);

   logic [CPU_QUANTITY-1:0] w_req;
   logic [CPU_QUANTITY-1:0] w_pick;
   logic [IDX_W-1:0]        w_pick_idx;
   logic                    w_sel_write;
   logic [ADDR_W-1:0]       w_addr_arr [CPU_QUANTITY];
   logic [DATA_W-1:0]       w_data_arr [CPU_QUANTITY];

   arb_state_t       r_state;
   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] r_idx;
   logic             r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   for (genvar g = 0; g < CPU_QUANTITY; g++) begin : g_split
      assign w_addr_arr[g] = cell_addr[g*ADDR_W +: ADDR_W];
      assign w_data_arr[g] = cell_data[g*DATA_W +: DATA_W];
   end

`ifdef CPU_ARB_WRITE_PRIO_EN
   assign w_req = (|cell_write_q) ? cell_write_q : cell_read_q;
`else
   assign w_req = cell_read_q | cell_write_q;
`endif

   rr_pick #(
      .N     (CPU_QUANTITY),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_req  (w_req),
      .i_last (r_last),
      .o_pick (w_pick)
   );

   always_comb begin
      w_pick_idx = '0;
      for (int i = 0; i < CPU_QUANTITY; i++) begin
         if (w_pick[i]) w_pick_idx = IDX_W'(i);
      end
   end

   // A cell raising both requests is served as a write; its read stays pending.
   assign w_sel_write = |(cell_write_q & w_pick);

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_state       <= ARB_IDLE;
         r_last        <= LAST_RST;
         r_idx         <= '0;
         r_write       <= 1'b0;
         r_addr        <= '0;
         r_data        <= '0;
         grant         <= '0;
         bus_busy      <= 1'b0;
         bus_read_q    <= 1'b0;
         bus_write_q   <= 1'b0;
         bus_addr      <= '0;
         bus_data      <= '0;
         cell_read_dn  <= '0;
         cell_write_dn <= '0;
         cell_data_out <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only; the done
         // pulses default low every cycle so each lasts exactly one cycle.
         cell_read_dn  <= '0;
         cell_write_dn <= '0;
         case (r_state)
            ARB_IDLE: begin
               if (|w_req && !rw_halt_in) begin
                  grant    <= w_pick;
                  r_idx    <= w_pick_idx;
                  r_addr   <= w_addr_arr[w_pick_idx];
                  r_data   <= w_data_arr[w_pick_idx];
                  r_write  <= w_sel_write;
                  bus_busy <= 1'b1;
                  r_state  <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               bus_addr    <= r_addr;
               bus_data    <= r_data;
               bus_write_q <= r_write;
               bus_read_q  <= !r_write;
               r_state     <= ARB_WAIT;
            end
            ARB_WAIT: begin
               // Only the done matching the transfer direction ends it.
               if (r_write ? bus_write_dn : bus_read_dn) begin
                  bus_read_q  <= 1'b0;
                  bus_write_q <= 1'b0;
                  if (!r_write) cell_data_out <= bus_data_in;
                  cell_write_dn[r_idx] <= r_write;
                  cell_read_dn[r_idx]  <= !r_write;
                  r_state <= ARB_DONE;
               end
            end
            ARB_DONE: begin
               r_last   <= r_idx;
               grant    <= '0;
               bus_busy <= 1'b0;
               r_state  <= ARB_IDLE;
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Round-robin arbiter that shares the single CPU-cell memory bus toward the dispatcher among `CPU_QUANTITY` cells. It replaces the wired-OR merging of per-cell read/write requests with an explicit one-grant-at-a-time sequence. It sits between the CpuCell array and DispatcherOfCpus inside CpuBlock. Each transfer is fully handshaken on both sides. `rw_halt_in` blocks new grants.

## Interface
- `CPU_QUANTITY`, 4: number of requesting cells; must be ≥ 2.
- `ADDR_W`, 32: address width, equal to `ADDR_SIZE`.
- `DATA_W`, 32: data width, equal to `DATA_SIZE`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `cell_read_q`  in  CPU_QUANTITY  per-cell read request, level.
- `cell_write_q`  in  CPU_QUANTITY  per-cell write request, level.
- `cell_addr`  in  CPU_QUANTITY*ADDR_W  per-cell address, flattened; cell i occupies [i*ADDR_W +: ADDR_W].
- `cell_data`  in  CPU_QUANTITY*DATA_W  per-cell write data, flattened.
- `cell_read_dn`  out  CPU_QUANTITY  one-cycle read-done pulse to the granted cell.
- `cell_write_dn`  out  CPU_QUANTITY  one-cycle write-done pulse to the granted cell.
- `cell_data_out`  out  DATA_W  read data; valid in the `cell_read_dn` cycle.
- `grant`  out  CPU_QUANTITY  one-hot current owner; zero when idle.
- `rw_halt_in`  in  1  high means no new grant is issued.
- `bus_read_q` / `bus_write_q`  out  1  downstream request.
- `bus_addr`  out  ADDR_W  downstream address.
- `bus_data`  out  DATA_W  downstream write data.
- `bus_read_dn` / `bus_write_dn`  in  1  downstream done.
- `bus_data_in`  in  DATA_W  downstream read data.
- `bus_busy`  out  1  high whenever the state is not IDLE.

## Operation
States are IDLE, ISSUE, WAIT, DONE.

- **IDLE:** If any request is pending and `rw_halt_in` is 0, select a cell by round-robin, starting the search at `last+1` (mod CPU_QUANTITY).
  - Register `grant`, the address, the data and the direction (write=1).
  - Go to ISSUE.
- **ISSUE:** Drive `bus_read_q` or `bus_write_q` with `bus_addr` and `bus_data` from the registered copies. Go to WAIT.
- **WAIT:** Hold the request until `bus_read_dn` or `bus_write_dn` matches the direction.
  - Capture `bus_data_in` into `cell_data_out`.
  - Drop the bus request and go to DONE.
  - The non-matching done is ignored.
- **DONE:** Pulse the matching `cell_*_dn[granted]` for one cycle and set `last`=granted.
  - Clear `grant` on exit and return to IDLE.
  - The cell must drop its request by the cycle after the dn pulse. A request still high in IDLE is treated as a new request.

Rules:
- A cell asserting both read_q and write_q is served as a write; the read stays pending.
- A request dropped by a cell after its grant does not abort the transfer. The downstream transfer completes, and the dn pulse is still issued and ignored by the cell.
- `rw_halt_in` rising during ISSUE or WAIT does not cancel the transfer in flight. It blocks only the next grant.
- `cell_data_out` holds its value until the next read completes.
- Reset values: every output is 0, state is IDLE, and `last`=CPU_QUANTITY-1 so that cell 0 wins first.
- Asserting `rst_in` mid-transfer drops all outputs to 0 immediately, without waiting for the downstream done.

## Timing
- The request is sampled in cycle T. `grant` is visible at T+1 and `bus_*_q` at T+2.
- Downstream done at cycle D drives `cell_*_dn` at D+1.
- Minimum occupancy is 4 cycles with a zero-wait downstream (done in the first WAIT cycle). A back-to-back grant therefore starts 4 cycles after the previous one.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- `CPU_ARB_WRITE_PRIO_EN`:
  - **Defined:** in IDLE, if any write is pending, only write requesters enter the round-robin search. Reads are served only when no write is pending.
  - **Undefined:** reads and writes share one round-robin order, and the request type is ignored for selection.
- `last` updates identically in both builds.

## Structure
- Package `cpu_arb_pkg` holds:
  - the state encoding constants `ARB_IDLE`/`ARB_ISSUE`/`ARB_WAIT`/`ARB_DONE` (2 bits);
  - default widths tied to `ADDR_SIZE`/`DATA_SIZE`.
- Sub-module `rr_pick`: purely combinational round-robin one-hot selector. Inputs are a request vector and the `last` index; output is a one-hot pick (zero if there are no requests). It is instantiated once, and the write-priority mask is applied before it.

## Test plan
- **Single read:** Reset, then cell 2 read_q at addr 0x100, with downstream read_dn 3 cycles after bus_read_q and data 0xDEADBEEF. Expect grant=0b0100 at T+1, bus_addr=0x100, then cell_read_dn[2] one pulse with cell_data_out=0xDEADBEEF.
- **Fairness:** All 4 cells hold read_q continuously with a zero-wait downstream. Expect grant order 0,1,2,3,0 and each grant 4 cycles apart.
- **Halt:** Set rw_halt_in=1 while cell 1 writes 0x55 to 0x20, with the transfer in WAIT. Expect the transfer to complete and write_dn[1] to pulse. A pending cell 3 gets no grant until halt drops, then grant=0b1000 one cycle later.
- **Write priority:** Cell 0 read and cell 1 write arrive together after reset. With `CPU_ARB_WRITE_PRIO_EN` defined, expect grant=0b0010 first. With it undefined, expect 0b0001 first.
- **Reset mid-transfer:** Pull rst_in low while bus_write_q=1. Expect every output to be 0 within the same cycle. After release, expect IDLE with cell 0 first in priority.
